irq_pending_latch: RTL
======================

# irq_pending_latch

Request-capture stage placed directly upstream of the 4-to-3 priority encoder. It synchronises four asynchronous request lines and detects their rising edges. Each edge is held in a sticky pending bit until the consumer acknowledges it by index. The masked pending vector drives the encoder's 4-bit `inp`, and the block records overrun events: a new edge arriving on a line that is still pending.

## Interface
Parameters:
- `SYNC_STAGES`, default 2. Synchroniser depth per line. Legal range is 2..4.

Ports:
- `clk`  input  1  Single clock. Every flop is on its rising edge.
- `rst_n`  input  1  Asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `clk`, which is guaranteed upstream.
- `req_i`  input  4  Asynchronous request lines; a rising edge is an event.
- `mask_i`  input  4  Synchronous per-line enable; 1 means the line is visible at `pend_o`.
- `ack_i`  input  1  Single-cycle acknowledge strobe.
- `ack_idx_i`  input  2  Index of the pending bit to clear when `ack_i` is 1.
- `ovr_clr_i`  input  1  Single-cycle strobe that clears all overrun flags.
- `pend_o`  output  4  Equals `pending & mask_i`; this is the encoder's `inp`.
- `any_o`  output  1  Equals `|pend_o`.
- `ovr_o`  output  4  Sticky per-line overrun flags.

## Operation
- Synchroniser: one shift chain per line, `SYNC_STAGES` flops deep, plus one history flop `hist`.
- `sync_out` is the last synchroniser stage. `rise[i] = sync_out[i] & ~hist[i]`, evaluated combinationally.
- Pending register, per line on each edge:
  - `pending[i] <= rise[i] | (pending[i] & ~clr[i])`.
  - `clr[i] = ack_i & (ack_idx_i == i)`.
  - If a set and a clear hit the same line in the same cycle, the set wins and `pending` stays 1.
- Overrun, per line:
  - `ovr[i]` sets when `rise[i] & pending[i] & ~clr[i]`.
  - With `ovr_clr_i` alone, all `ovr` bits go to 0.
  - If `ovr_clr_i` and a new overrun occur in the same cycle, that line's bit sets and the others clear.
- Mask:
  - Masking affects only `pend_o`/`any_o`. Masked lines still capture edges, pend, and flag overruns.
  - Unmasking a pending line exposes it in the same cycle, combinationally.
  - An ack of a masked or non-pending line is legal. It is a no-op when nothing is pending on that line.
- Only one ack is accepted per cycle. `ack_idx_i` is ignored when `ack_i` is 0.
- Levels carry no meaning; only 0→1 transitions of the synchronised line create events. A line held high creates exactly one event.

## Timing
- Reset values: all sync flops and `hist` are 0, `pending` is 4'b0000, `ovr_o` is 4'b0000, `pend_o` is 4'b0000, and `any_o` is 0.
- Latency:
  - A `req_i` rise set up before edge k appears in `sync_out` after edge k+SYNC_STAGES-1.
  - `pending` is set at edge k+SYNC_STAGES. With the default depth, `pend_o` goes high 2 edges after sampling.
- Ack latency: `ack_i` sampled at edge k clears the bit after edge k. `pend_o` drops in the following cycle.
- Minimum capture: a `req_i` pulse must be high for at least one full clock period plus setup. Shorter pulses may be lost; this is not an error.
- Re-arm: a line must be seen low in `sync_out` for at least one cycle before its next rise counts.
- Reset mid-operation: asynchronous clear of all state. If a line is high when `rst_n` is released, it produces one event SYNC_STAGES edges later, because `hist` restarts at 0.

## Test plan
- Reset, then `req_i` goes 4'b0000 → 4'b0100 with `mask_i` = 4'hF. Required: `pend_o` = 4'b0100 and `any_o` = 1 exactly 2 edges after sampling; `ovr_o` = 0.
- Line 2 pending, then `ack_i` = 1 with `ack_idx_i` = 2 for one cycle. Required: `pend_o` = 0 in the next cycle and `any_o` = 0.
- Pulse line 1 twice (rise, fall, rise) with no ack in between. Required: `pending[1]` = 1 and `ovr_o` = 4'b0010. Then pulse `ovr_clr_i`. Required: `ovr_o` = 0 and `pending[1]` still 1.
- Ack of line 3 lands in the same cycle as a new rise on line 3. Required: `pend_o[3]` stays 1 and `ovr_o[3]` stays 0.
- `mask_i` = 4'b1110 and rise on line 0. Required: `pend_o` = 0 and `any_o` = 0. Then `mask_i` = 4'hF. Required: `pend_o` = 4'b0001 in the same cycle.
- Apply `req_i` = 4'hF, assert `rst_n` = 0 mid-run, then release. Required: all outputs are 0 during reset. After release, `pend_o` = 4'hF 2 edges later, with no overrun flagged.

Source files
------------

// File: rtl/irq_pending_latch.sv
// irq_pending_latch
// Request-capture stage in front of the 4-to-3 priority encoder. Each of the
// four asynchronous request lines is synchronised, and its rising edges are
// detected. A detected edge is held in a sticky pending bit until the consumer
// acknowledges that line by index. The masked pending vector feeds the encoder.
// An overrun flag records a new edge that arrives while the line is still
// pending.
//
// Strobe semantics: ack_i and ovr_clr_i are single-cycle strobes sampled on
// every rising clk edge. No backpressure applies. ack_idx_i is only examined
// while ack_i is 1. An ack of a line that is not pending has no effect.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
    input  logic [3:0] mask_i,
    input  logic       ack_i,
    input  logic [1:0] ack_idx_i,
    input  logic       ovr_clr_i,
    output logic [3:0] pend_o,
    output logic       any_o,
    output logic [3:0] ovr_o
);

    // Synchroniser chain: stage 0 samples req_i and the last stage is sync_out.
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] hist_q;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [3:0] ovr_q;
    logic [3:0] ovr_d;

    logic [3:0] sync_out;
    logic [3:0] rise;
    logic [3:0] clr;

    // Shift the request lines through the synchroniser and keep one cycle of history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= 4'b0000;
            end
            hist_q <= 4'b0000;
        end else begin
            sync_q[0] <= req_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_out;
        end
    end

    // Detect edges and decode the acknowledge.
    // A line must be seen low before its next rise counts, so a held level
    // produces exactly one event.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        rise     = sync_out & ~hist_q;
        clr      = ack_i ? (4'b0001 << ack_idx_i) : 4'b0000;
    end

    // Compute the next pending and overrun state.
    // A new edge beats a same-cycle ack on the same line, so the bit stays set.
    // When that happens it is not an overrun, because the old event is consumed.
    // A fresh overrun also beats a same-cycle ovr_clr_i on its own line.
    always_comb begin
        pend_d = rise | (pend_q & ~clr);
        ovr_d  = (ovr_q & {4{~ovr_clr_i}}) | (rise & pend_q & ~clr);
    end

    // Register the pending and overrun state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 4'b0000;
            ovr_q  <= 4'b0000;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    // Drive the outputs. The mask acts only here, so an unmasked pending line
    // appears in the same cycle.
    always_comb begin
        pend_o = pend_q & mask_i;
        any_o  = |pend_o;
        ovr_o  = ovr_q;
    end

endmodule
